key_cmd_encoder: RTL and testbench
==================================

Name: key_cmd_encoder

Overview:
- Front-end command source for the LED command bus: synchronises and debounces three raw push-buttons, turns each press into a command byte, and queues the commands in a small FIFO.
- Queued commands are presented on a valid/ready stream that feeds the LED controller directly.
- Replaces simulated key stimulus with real key handling, including backpressure from the controller's busy periods.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles at a new level before the debounced state changes (≥1).
- DB_CNT_W, 8, debounce counter width; must satisfy 2^DB_CNT_W > DEBOUNCE_CYCLES.
- FIFO_DEPTH, 4, command queue entries; power of 2, ≥2.
- PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- key_on  in  1  raw asynchronous button, active-high.
- key_off  in  1  raw asynchronous button, active-high.
- key_breath  in  1  raw asynchronous button, active-high.
- valid  out  1  command available on data_out.
- ready  in  1  consumer accepts when valid && ready at a rising edge.
- data_out  out  8  command byte.
- fifo_count  out  PTR_W+1  entries currently queued (0..FIFO_DEPTH).
- dropped  out  1  sticky flag: at least one press was lost since reset.

Behaviour:
- Reset (rst=1 at an edge):
  - valid=0, data_out=8'h00, fifo_count=0, dropped=0.
  - Synchronisers, debounced states and counters are cleared to 0, so every key is treated as released.
  - Reset overrides all other activity, including mid-transfer. Queued commands are discarded.
- Synchroniser: each key passes through a 2-flop synchroniser; the second flop is the "sync" level.
- Debounce, per key:
  - Counter clears in any cycle where sync == stable.
  - When sync != stable, the counter increments.
  - At the edge where counter == DEBOUNCE_CYCLES-1 and sync != stable: stable <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES leaves stable unchanged.
- Press event: combinational pulse when stable is 1 and its previous-cycle value is 0. Release generates nothing.
- Encoding: key_on→8'h01, key_off→8'h02, key_breath→8'hFF.
  - Several press events in one cycle: only the highest-priority one is written (breath > off > on).
  - The lower-priority events are lost and dropped is set.
- Latency:
  - A raw key first sampled high at edge k, held steady, writes into the FIFO at edge k+DEBOUNCE_CYCLES+2.
  - valid is high in the following cycle when the FIFO was empty.
  - There is no combinational path from keys to valid/data_out.
- FIFO:
  - Circular buffer with write and read pointers, plus a count.
  - data_out always shows the head entry while valid=1; valid = (count != 0), registered.
  - Pop on valid && ready.
  - data_out and valid stay stable while valid && !ready.
  - When empty, data_out holds its last value.
- Boundary conditions:
  - Push with no pop: count+1.
  - Pop with no push: count-1.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is allowed when full (push accepted) and when count==1 (new entry becomes head next cycle).
  - Push while full with no pop: event discarded, dropped <= 1, FIFO unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- dropped: sticky until rst.
- Key held through reset: stable is cleared, so after rst deasserts it is detected as one new press after debounce.

Test Plan:
- Reset: assert rst 3 cycles with keys low -> valid=0, data_out=8'h00, fifo_count=0, dropped=0.
- Clean press: ready=1, key_breath raised before edge 0 and held, DEBOUNCE_CYCLES=4 -> FIFO write at edge 6, valid=1 with data_out=8'hFF for exactly one cycle, fifo_count returns to 0. No second command while the key is held or when it is released.
- Bounce: key_on toggles every 2 cycles for 12 cycles, then held high -> exactly one 8'h01 beat, dropped=0.
- Backpressure: ready=0, press on, off, breath in sequence -> fifo_count=3, data_out=8'h01 stable. Then ready=1 -> beats 8'h01, 8'h02, 8'hFF on three consecutive edges, then valid=0.
- Overflow and collision:
  - ready=0, five separate key_on presses -> fifo_count=4, dropped=1.
  - After draining, exactly four 8'h01 beats.
  - Separately, key_on and key_breath rise in the same cycle -> only 8'hFF queued, dropped=1.
- Reset mid-operation: 2 entries queued and key_off held, pulse rst 1 cycle -> fifo_count=0, valid=0 next cycle. Then one 8'h02 appears after DEBOUNCE_CYCLES+2 edges because the key is still held.

Source files
------------

// File: rtl/key_cmd_encoder_if.sv
// key_cmd_encoder_if
//   Valid/ready command stream from the key front-end to the LED controller.
//   Signals:
//     valid     command byte available on data_out
//     ready     consumer accepts the byte when valid && ready at a rising edge
//     data_out  8-bit command byte
//   Modports:
//     master  drives valid/data_out, samples ready (key_cmd_encoder)
//     slave   samples valid/data_out, drives ready (LED controller)

interface key_cmd_encoder_if;
    logic       valid;
    logic       ready;
    logic [7:0] data_out;

    modport master (
        output valid,
        output data_out,
        input  ready
    );

    modport slave (
        input  valid,
        input  data_out,
        output ready
    );
endinterface

// File: rtl/key_cmd_encoder.sv
// key_cmd_encoder
//   Synchronises and debounces three raw push-buttons, turns each press into
//   a command byte and queues the commands in a small FIFO that feeds the LED
//   controller over a valid/ready stream.
//   Ports:
//     clk         single clock, rising edge
//     rst         synchronous active-high reset
//     key_on      raw button, active-high     -> command 8'h01
//     key_off     raw button, active-high     -> command 8'h02
//     key_breath  raw button, active-high     -> command 8'hFF
//     cmd         key_cmd_encoder_if master (valid, ready, data_out)
//     fifo_count  entries currently queued (0..FIFO_DEPTH)
//     dropped     sticky: at least one press was lost since reset
//   Parameters:
//     DEBOUNCE_CYCLES  consecutive cycles at a new level before it is accepted
//     DB_CNT_W         debounce counter width (2**DB_CNT_W > DEBOUNCE_CYCLES)
//     FIFO_DEPTH       queue entries, power of two
//     PTR_W            log2(FIFO_DEPTH)

module key_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_CNT_W        = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int PTR_W           = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_on,
    input  logic                 key_off,
    input  logic                 key_breath,
    key_cmd_encoder_if.master    cmd,
    output logic [PTR_W:0]       fifo_count,
    output logic                 dropped
);

    localparam int NUM_KEYS = 3;

    localparam logic [DB_CNT_W-1:0] DB_LAST    = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]      FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [7:0] CMD_ON     = 8'h01;
    localparam logic [7:0] CMD_OFF    = 8'h02;
    localparam logic [7:0] CMD_BREATH = 8'hFF;

    // bit 0 = on, bit 1 = off, bit 2 = breath
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] sync_a;
    logic [NUM_KEYS-1:0] sync_b;
    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] stable_d;
    logic [NUM_KEYS-1:0] press;
    logic [DB_CNT_W-1:0] db_cnt [NUM_KEYS];

    assign key_raw = {key_breath, key_off, key_on};

    // ------------------------------------------------------------------
    // Two-flop synchronisers; sync_b is the level the debouncer sees.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= key_raw;
            sync_b <= sync_a;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: the counter measures how long sync has disagreed with the
    // accepted level; any agreeing cycle restarts the measurement.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            stable_d <= stable;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync_b[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rising edge of the debounced level; releases produce nothing.
    assign press = stable & ~stable_d;

    // ------------------------------------------------------------------
    // Command encoding with fixed priority breath > off > on. Any losing
    // press in the same cycle is reported through dropped.
    // ------------------------------------------------------------------
    logic       push;
    logic [7:0] push_data;
    logic       collide;

    always_comb begin
        push      = 1'b0;
        push_data = 8'h00;
        if (press[2]) begin
            push      = 1'b1;
            push_data = CMD_BREATH;
        end else if (press[1]) begin
            push      = 1'b1;
            push_data = CMD_OFF;
        end else if (press[0]) begin
            push      = 1'b1;
            push_data = CMD_ON;
        end
    end

    assign collide = (press[2] & (press[1] | press[0])) | (press[1] & press[0]);

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             valid_r;
    logic [7:0]       data_r;
    logic [7:0]       head_next;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             overflow;

    assign full     = (count == FULL_COUNT);
    assign pop      = valid_r & cmd.ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push & (~full | pop);
    assign overflow = push & full & ~pop;

    assign rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // The entry being written this cycle is the next head only when the
    // queue ends up holding exactly that one entry (empty push, or
    // push+pop with one entry); otherwise the head is already in memory.
    always_comb begin
        head_next = mem[rd_ptr_next];
        if (push_ok && (wr_ptr == rd_ptr_next)) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_r <= 1'b0;
            data_r  <= 8'h00;
            dropped <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            rd_ptr  <= rd_ptr_next;
            count   <= count_next;
            valid_r <= (count_next != '0);
            // Output register keeps the last head when the queue drains.
            if (count_next != '0) begin
                data_r <= head_next;
            end
            if (collide || overflow) begin
                dropped <= 1'b1;
            end
        end
    end

    assign cmd.valid    = valid_r;
    assign cmd.data_out = data_r;
    assign fifo_count   = count;

endmodule

// File: tb/tb_key_cmd_encoder.sv
module tb_key_cmd_encoder;

    localparam int DB    = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] keys = 3'b000;      // bit0 on, bit1 off, bit2 breath
    logic       rdy = 1'b0;
    logic [2:0] fifo_count;
    logic       dropped;

    key_cmd_encoder_if bus();
    assign bus.ready = rdy;

    key_cmd_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .DB_CNT_W(8),
        .FIFO_DEPTH(DEPTH),
        .PTR_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_on(keys[0]),
        .key_off(keys[1]),
        .key_breath(keys[2]),
        .cmd(bus),
        .fifo_count(fifo_count),
        .dropped(dropped)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Raw keys reach the debouncer two edges late; a key's accepted level
    // changes once the last DB samples all disagree with it. Presses are
    // rising edges of the accepted level, queued in an SV queue.
    bit [2:0] m_s1, m_s2, m_stable, m_prev;
    bit [2:0] m_hist[$];
    bit [7:0] m_q[$];
    bit       m_drop;
    bit [7:0] m_data;

    task automatic model_edge(input bit [2:0] raw, input bit r_in, input bit r);
        bit [2:0] ev;
        bit [2:0] nstab;
        bit       pop;
        int       sz;
        bit       all_diff;
        bit [7:0] c;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_prev = 0;
            m_hist.delete(); m_q.delete();
            m_drop = 0; m_data = 8'h00;
            return;
        end
        ev  = m_stable & ~m_prev;
        sz  = m_q.size();
        pop = (sz != 0) && r_in;
        if ($countones(ev) > 1) m_drop = 1;
        if (pop) void'(m_q.pop_front());
        if (ev != 0) begin
            c = ev[2] ? 8'hFF : (ev[1] ? 8'h02 : 8'h01);
            if (sz == DEPTH && !pop) m_drop = 1;
            else m_q.push_back(c);
        end
        m_hist.push_back(m_s2);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        nstab = m_stable;
        for (int i = 0; i < 3; i++) begin
            all_diff = (m_hist.size() == DB);
            foreach (m_hist[j]) if (m_hist[j][i] == m_stable[i]) all_diff = 0;
            if (all_diff) nstab[i] = ~m_stable[i];
        end
        m_prev   = m_stable;
        m_stable = nstab;
        m_s2     = m_s1;
        m_s1     = raw;
        if (m_q.size() != 0) m_data = m_q[0];
    endtask

    // One clock: advance model with the inputs the DUT samples, then compare.
    task automatic tick();
        model_edge(keys, rdy, rst);
        @(posedge clk);
        #1;
        chk("model_valid", int'(bus.valid), int'(m_q.size() != 0));
        chk("model_data", int'(bus.data_out), int'(m_data));
        chk("model_count", int'(fifo_count), m_q.size());
        chk("model_dropped", int'(dropped), int'(m_drop));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        bit       rst;
        bit [2:0] keys;
        bit       rdy;
        int       cycles;
        bit       exp_valid;
        bit [7:0] exp_data;
        int       exp_count;
        bit       exp_drop;
    } vec_t;

    vec_t vecs[$];

    int beats;
    int seen_valid;

    initial begin
        // press/release phases, each long enough to debounce fully
        vecs.push_back('{0, 3'b001, 0, 8, 1, 8'h01, 1, 0});
        vecs.push_back('{0, 3'b000, 0, 8, 1, 8'h01, 1, 0});
        vecs.push_back('{0, 3'b010, 0, 8, 1, 8'h01, 2, 0});
        vecs.push_back('{0, 3'b000, 0, 8, 1, 8'h01, 2, 0});
        vecs.push_back('{0, 3'b100, 0, 8, 1, 8'h01, 3, 0});
        vecs.push_back('{0, 3'b000, 0, 8, 1, 8'h01, 3, 0});
        vecs.push_back('{0, 3'b000, 1, 1, 1, 8'h02, 2, 0});
        vecs.push_back('{0, 3'b000, 1, 1, 1, 8'hFF, 1, 0});
        vecs.push_back('{0, 3'b000, 1, 1, 0, 8'hFF, 0, 0});
        // overflow: five presses into a four-entry queue
        for (int p = 1; p <= 5; p++) begin
            vecs.push_back('{0, 3'b001, 0, 8, 1, 8'h01, (p > 4) ? 4 : p, p > 4});
            vecs.push_back('{0, 3'b000, 0, 8, 1, 8'h01, (p > 4) ? 4 : p, p > 4});
        end
        vecs.push_back('{0, 3'b000, 1, 1, 1, 8'h01, 3, 1});
        vecs.push_back('{0, 3'b000, 1, 1, 1, 8'h01, 2, 1});
        vecs.push_back('{0, 3'b000, 1, 1, 1, 8'h01, 1, 1});
        vecs.push_back('{0, 3'b000, 1, 1, 0, 8'h01, 0, 1});
        vecs.push_back('{0, 3'b000, 1, 4, 0, 8'h01, 0, 1});
        // collision: on and breath together
        vecs.push_back('{1, 3'b000, 0, 1, 0, 8'h00, 0, 0});
        vecs.push_back('{0, 3'b101, 0, 8, 1, 8'hFF, 1, 1});
        vecs.push_back('{0, 3'b000, 0, 8, 1, 8'hFF, 1, 1});
        vecs.push_back('{1, 3'b000, 1, 1, 0, 8'h00, 0, 0});

        // reset for three cycles
        rst = 1; keys = 0; rdy = 0;
        ticks(3);
        chk("reset_valid", int'(bus.valid), 0);
        chk("reset_data", int'(bus.data_out), 0);
        chk("reset_count", int'(fifo_count), 0);
        chk("reset_dropped", int'(dropped), 0);
        rst = 0;

        foreach (vecs[v]) begin
            rst = vecs[v].rst; keys = vecs[v].keys; rdy = vecs[v].rdy;
            ticks(vecs[v].cycles);
            chk($sformatf("vec%0d_valid", v), int'(bus.valid), int'(vecs[v].exp_valid));
            chk($sformatf("vec%0d_data", v), int'(bus.data_out), int'(vecs[v].exp_data));
            chk($sformatf("vec%0d_count", v), int'(fifo_count), vecs[v].exp_count);
            chk($sformatf("vec%0d_dropped", v), int'(dropped), int'(vecs[v].exp_drop));
        end
        rst = 0; keys = 0; rdy = 1;
        ticks(2);

        // clean press latency: first sample at tick 1, write at tick 7
        keys = 3'b100;
        seen_valid = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (bus.valid) seen_valid++;
        end
        chk("clean_early_valid", seen_valid, 0);
        tick();
        chk("clean_valid", int'(bus.valid), 1);
        chk("clean_data", int'(bus.data_out), 8'hFF);
        tick();
        chk("clean_one_beat", int'(bus.valid), 0);
        chk("clean_count", int'(fifo_count), 0);
        beats = 0;
        ticks(1);
        for (int t = 0; t < 10; t++) begin tick(); if (bus.valid) beats++; end
        keys = 0;
        for (int t = 0; t < 10; t++) begin tick(); if (bus.valid) beats++; end
        chk("clean_no_repeat", beats, 0);

        // bounce on key_on, then held
        beats = 0;
        for (int t = 0; t < 12; t++) begin
            keys = ((t / 2) % 2 == 0) ? 3'b001 : 3'b000;
            tick();
            if (bus.valid) beats++;
        end
        keys = 3'b001;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (bus.valid) begin
                beats++;
                chk("bounce_data", int'(bus.data_out), 8'h01);
            end
        end
        keys = 0;
        for (int t = 0; t < 12; t++) begin tick(); if (bus.valid) beats++; end
        chk("bounce_beats", beats, 1);
        chk("bounce_dropped", int'(dropped), 0);

        // reset mid-operation with key_off held through reset
        rdy = 0;
        keys = 3'b001; ticks(8); keys = 0; ticks(8);
        keys = 3'b001; ticks(8); keys = 0; ticks(8);
        chk("midrst_pre_count", int'(fifo_count), 2);
        keys = 3'b010; ticks(10);
        rst = 1; tick(); rst = 0;
        chk("midrst_count", int'(fifo_count), 0);
        chk("midrst_valid", int'(bus.valid), 0);
        seen_valid = 0;
        for (int t = 1; t <= 6; t++) begin tick(); if (bus.valid) seen_valid++; end
        chk("midrst_early_valid", seen_valid, 0);
        tick();
        chk("midrst_new_valid", int'(bus.valid), 1);
        chk("midrst_new_data", int'(bus.data_out), 8'h02);
        chk("midrst_new_count", int'(fifo_count), 1);
        keys = 0; rdy = 1; ticks(10);

        // randomized stimulus against the model
        for (int t = 0; t < 4000; t++) begin
            if ($urandom_range(0, 5) == 0) keys[$urandom_range(0, 2)] ^= 1'b1;
            if ((t / 300) % 2 == 0) rdy = ($urandom_range(0, 3) != 0);
            else rdy = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
